// File: rtl/debug_pkg.sv
// debug_pkg: shared definitions for the debug run controller.
//   - FSM state encoding, also the STATUS[1:0] code seen by host software.
//   - Avalon-MM register addresses (0-7).
//   - CTRL register bit positions.
package debug_pkg;

  typedef enum logic [1:0] {
    ST_HALTED   = 2'd0,
    ST_RUNNING  = 2'd1,
    ST_STEPPING = 2'd2
  } dbg_state_e;

  localparam logic [2:0] ADDR_CTRL       = 3'd0;
  localparam logic [2:0] ADDR_STATUS     = 3'd1;
  localparam logic [2:0] ADDR_BP_PC      = 3'd2;
  localparam logic [2:0] ADDR_STEP_COUNT = 3'd3;
  localparam logic [2:0] ADDR_RETIRE_CNT = 3'd4;
  localparam logic [2:0] ADDR_HALT_PC    = 3'd5;
  localparam logic [2:0] ADDR_CYC_LO     = 3'd6;
  localparam logic [2:0] ADDR_CYC_HI     = 3'd7;

  localparam int CTRL_RUN     = 0;
  localparam int CTRL_HALT    = 1;
  localparam int CTRL_STEP    = 2;
  localparam int CTRL_BP_EN   = 3;
  localparam int CTRL_CLR_CNT = 4;

endpackage

// File: rtl/debug_cycle_counter.sv
// debug_cycle_counter: 32-bit cycle counter with a shadow of the upper half.
// Reading the low half latches the high half so the host gets a coherent
// 32-bit value from two 16-bit reads.
// Ports:
//   clk, reset     clock, asynchronous active-high reset
//   count_en       increment this cycle
//   clear          zero the counter (wins over count_en)
//   latch_hi       copy count[31:16] into the shadow
//   count_lo       count[15:0]
//   hi_shadow      shadowed count[31:16]
module debug_cycle_counter (
  input  logic        clk,
  input  logic        reset,
  input  logic        count_en,
  input  logic        clear,
  input  logic        latch_hi,
  output logic [15:0] count_lo,
  output logic [15:0] hi_shadow
);

  logic [31:0] count_reg;
  logic [15:0] shadow_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_reg  <= 32'd0;
      shadow_reg <= 16'd0;
    end else begin
      if (clear)
        count_reg <= 32'd0;
      else if (count_en)
        count_reg <= count_reg + 32'd1;
      // Shadow takes the same pre-edge value whose low half is being read.
      if (latch_hi)
        shadow_reg <= count_reg[31:16];
    end
  end

  assign count_lo  = count_reg[15:0];
  assign hi_shadow = shadow_reg;

endmodule

// File: rtl/debug_run_controller.sv
// debug_run_controller: run/halt/single-step controller for the soft processor.
// Gates forward progress with cpu_pause, implements one PC breakpoint, counts
// retired instructions and captures the halt PC. Control/status is a 16-bit
// Avalon-MM slave with read latency 1.
// Optional feature: define DEBUG_CYCLE_COUNTER_EN to build a 32-bit cycle
// counter at addresses 6/7; otherwise those addresses read 0.
// Ports:
//   clk, reset                      clock, asynchronous active-high reset
//   avl_address/read/write/writedata Avalon-MM slave inputs
//   avl_readdata                    registered read data
//   current_pc, instr_retire        retirement info from the processor
//   cpu_pause                       high while HALTED
module debug_run_controller
  import debug_pkg::*;
#(
  parameter int PC_WIDTH      = 10,
  parameter bit START_RUNNING = 1'b0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [2:0]          avl_address,
  input  logic                avl_read,
  input  logic                avl_write,
  input  logic [15:0]         avl_writedata,
  output logic [15:0]         avl_readdata,
  input  logic [PC_WIDTH-1:0] current_pc,
  input  logic                instr_retire,
  output logic                cpu_pause
);

  localparam dbg_state_e RESET_STATE = START_RUNNING ? ST_RUNNING : ST_HALTED;

  dbg_state_e          state_reg;
  logic [15:0]         remaining_reg;
  logic                bp_hit_reg;
  logic                bp_en_reg;
  logic [PC_WIDTH-1:0] bp_pc_reg;
  logic [15:0]         step_count_reg;
  logic [15:0]         retire_cnt_reg;
  logic [PC_WIDTH-1:0] halt_pc_reg;
  logic [PC_WIDTH-1:0] last_pc_reg;
  logic [15:0]         readdata_reg;
  logic [15:0]         read_next;
  logic [15:0]         cyc_lo_word;
  logic [15:0]         cyc_hi_word;

  // Command decode
  logic wr_ctrl, cmd_run, cmd_halt, cmd_step, cmd_clr;
  logic bp_match, step_done, halt_entry;

  assign wr_ctrl  = avl_write && (avl_address == ADDR_CTRL);
  assign cmd_run  = wr_ctrl && avl_writedata[CTRL_RUN];
  assign cmd_halt = wr_ctrl && avl_writedata[CTRL_HALT];
  assign cmd_step = wr_ctrl && avl_writedata[CTRL_STEP];
  assign cmd_clr  = wr_ctrl && avl_writedata[CTRL_CLR_CNT];

  assign bp_match  = instr_retire && bp_en_reg && (current_pc == bp_pc_reg);
  assign step_done = (state_reg == ST_STEPPING) && instr_retire &&
                     (remaining_reg == 16'd1);
  assign halt_entry = (state_reg != ST_HALTED) &&
                      (cmd_halt || bp_match || step_done);

  // Run-control FSM
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= RESET_STATE;
      remaining_reg <= 16'd0;
      bp_hit_reg    <= 1'b0;
      halt_pc_reg   <= '0;
      last_pc_reg   <= '0;
    end else begin
      if (instr_retire)
        last_pc_reg <= current_pc;
      // The instruction retiring on the halting cycle is the halt PC.
      if (halt_entry)
        halt_pc_reg <= instr_retire ? current_pc : last_pc_reg;

      case (state_reg)
        ST_HALTED: begin
          // HALT beats RUN/STEP; STEP beats RUN.
          if (!cmd_halt) begin
            if (cmd_step) begin
              state_reg     <= ST_STEPPING;
              remaining_reg <= (step_count_reg == 16'd0) ? 16'd1 : step_count_reg;
              bp_hit_reg    <= 1'b0;
            end else if (cmd_run) begin
              state_reg  <= ST_RUNNING;
              bp_hit_reg <= 1'b0;
            end
          end
        end
        ST_RUNNING: begin
          if (bp_match)
            bp_hit_reg <= 1'b1;
          if (cmd_halt || bp_match)
            state_reg <= ST_HALTED;
        end
        ST_STEPPING: begin
          if (bp_match)
            bp_hit_reg <= 1'b1;
          if (instr_retire)
            remaining_reg <= remaining_reg - 16'd1;
          if (cmd_halt || bp_match || step_done)
            state_reg <= ST_HALTED;
        end
        default: state_reg <= ST_HALTED;
      endcase
    end
  end

  // Writable registers and retire counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bp_en_reg      <= 1'b0;
      bp_pc_reg      <= '0;
      step_count_reg <= 16'd0;
      retire_cnt_reg <= 16'd0;
    end else begin
      if (wr_ctrl)
        bp_en_reg <= avl_writedata[CTRL_BP_EN];
      if (avl_write && (avl_address == ADDR_BP_PC))
        bp_pc_reg <= avl_writedata[PC_WIDTH-1:0];
      if (avl_write && (avl_address == ADDR_STEP_COUNT))
        step_count_reg <= avl_writedata;
      // Clear wins over a coincident retire.
      if (cmd_clr)
        retire_cnt_reg <= 16'd0;
      else if (instr_retire)
        retire_cnt_reg <= retire_cnt_reg + 16'd1;
    end
  end

`ifdef DEBUG_CYCLE_COUNTER_EN
  debug_cycle_counter u_cycle_counter (
    .clk       (clk),
    .reset     (reset),
    .count_en  (state_reg != ST_HALTED),
    .clear     (cmd_clr),
    .latch_hi  (avl_read && (avl_address == ADDR_CYC_LO)),
    .count_lo  (cyc_lo_word),
    .hi_shadow (cyc_hi_word)
  );
`else
  // Without the counter the read strobe has no side effects.
  logic unused_avl_read;
  assign unused_avl_read = avl_read;
  assign cyc_lo_word     = 16'd0;
  assign cyc_hi_word     = 16'd0;
`endif

  // Read mux, registered every cycle from the address
  always_comb begin
    read_next = 16'd0;
    case (avl_address)
      ADDR_CTRL:       read_next = {15'd0, bp_en_reg};
      ADDR_STATUS:     read_next = {13'd0, bp_hit_reg, state_reg};
      ADDR_BP_PC:      read_next = 16'(bp_pc_reg);
      ADDR_STEP_COUNT: read_next = step_count_reg;
      ADDR_RETIRE_CNT: read_next = retire_cnt_reg;
      ADDR_HALT_PC:    read_next = 16'(halt_pc_reg);
      ADDR_CYC_LO:     read_next = cyc_lo_word;
      ADDR_CYC_HI:     read_next = cyc_hi_word;
      default:         read_next = 16'd0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      readdata_reg <= 16'd0;
    else
      readdata_reg <= read_next;
  end

  assign avl_readdata = readdata_reg;
  assign cpu_pause    = (state_reg == ST_HALTED);

endmodule
